// File: rtl/calc_pkg.sv
// Shared calculator definitions: key-entry FSM states and the ASCII keycodes
// used by both the key-entry front end and the arithmetic block.
package calc_pkg;

  typedef enum logic [1:0] {
    NUM1 = 2'd0,
    NUM2 = 2'd1,
    DONE = 2'd2
  } calc_state_t;

  localparam logic [7:0] KEY_ADD = 8'h61;
  localparam logic [7:0] KEY_SUB = 8'h62;
  localparam logic [7:0] KEY_MUL = 8'h63;
  localparam logic [7:0] KEY_DIV = 8'h64;
  localparam logic [7:0] KEY_EQ  = 8'h65;
  localparam logic [7:0] KEY_D0  = 8'h30;
  localparam logic [7:0] KEY_D9  = 8'h39;

  function automatic logic in_range(input logic [7:0] code,
                                    input logic [7:0] lo,
                                    input logic [7:0] hi);
    return (code >= lo) && (code <= hi);
  endfunction

endpackage

// File: rtl/calc_key_class.sv
// Combinational keycode classifier: splits an ASCII code into the key classes
// the entry FSM acts on. Unlisted codes assert no class at all.
module calc_key_class
  import calc_pkg::*;
#(
  parameter logic [7:0] KEY_CLR = 8'h1B,
  parameter logic [7:0] KEY_BS  = 8'h08
) (
  input  logic [7:0] i_code,
  output logic       o_is_digit,
  output logic       o_is_op,
  output logic       o_is_eq,
  output logic       o_is_clr,
  output logic       o_is_bs,
  output logic [3:0] o_digit_val
);

  // Decode key class; for ASCII digits the low nibble is the digit value
  always_comb begin
    o_is_digit  = in_range(i_code, KEY_D0, KEY_D9);
    o_is_op     = in_range(i_code, KEY_ADD, KEY_DIV);
    o_is_eq     = (i_code == KEY_EQ);
    o_is_clr    = (i_code == KEY_CLR);
    o_is_bs     = (i_code == KEY_BS);
    o_digit_val = i_code[3:0];
  end

endmodule

// File: rtl/calc_key_entry.sv
// Calculator key-entry front end: assembles two packed-BCD operands and an
// operator from keyboard strobes, pulsing op_valid when "= " completes a sum.
module calc_key_entry
  import calc_pkg::*;
#(
  parameter int         DIGITS  = 3,
  parameter logic [7:0] KEY_CLR = 8'h1B,
  parameter logic [7:0] KEY_BS  = 8'h08
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  key_valid,
  input  logic [7:0]            key_code,
  output logic [4*DIGITS-1:0]   reg_num1,
  output logic [4*DIGITS-1:0]   reg_num2,
  output logic [7:0]            sym,
  output logic                  op_valid,
  output logic                  err,
  output logic                  busy
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = $clog2(DIGITS + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DIGITS);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  logic            w_is_digit;
  logic            w_is_op;
  logic            w_is_eq;
  logic            w_is_clr;
  logic            w_is_bs;
  logic [3:0]      w_digit_val;

  calc_state_t     r_state;
  logic [CW-1:0]   r_cnt1;
  logic [CW-1:0]   r_cnt2;

  calc_key_class #(
    .KEY_CLR (KEY_CLR),
    .KEY_BS  (KEY_BS)
  ) u_class (
    .i_code      (key_code),
    .o_is_digit  (w_is_digit),
    .o_is_op     (w_is_op),
    .o_is_eq     (w_is_eq),
    .o_is_clr    (w_is_clr),
    .o_is_bs     (w_is_bs),
    .o_digit_val (w_digit_val)
  );

  // Entry FSM with operand, operator and pulse outputs all registered here
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= NUM1;
      r_cnt1   <= CNT_ZERO;
      r_cnt2   <= CNT_ZERO;
      reg_num1 <= '0;
      reg_num2 <= '0;
      sym      <= 8'h00;
      op_valid <= 1'b0;
      err      <= 1'b0;
      busy     <= 1'b0;
    end else begin
      op_valid <= 1'b0;
      err      <= 1'b0;
      if (key_valid && w_is_clr) begin
        r_state  <= NUM1;
        r_cnt1   <= CNT_ZERO;
        r_cnt2   <= CNT_ZERO;
        reg_num1 <= '0;
        reg_num2 <= '0;
        sym      <= 8'h00;
        busy     <= 1'b0;
      end else if (key_valid) begin
        case (r_state)
          NUM1: begin
            if (w_is_digit) begin
              if (r_cnt1 == CNT_FULL) begin
                err <= 1'b1;
              end else begin
                reg_num1 <= {reg_num1[W-5:0], w_digit_val};
                r_cnt1   <= r_cnt1 + CNT_ONE;
              end
            end else if (w_is_op) begin
              if (r_cnt1 != CNT_ZERO) begin
                sym     <= key_code;
                r_state <= NUM2;
                busy    <= 1'b1;
              end else begin
                err <= 1'b1;
              end
            end else if (w_is_eq) begin
              err <= 1'b1;
            end else if (w_is_bs && (r_cnt1 != CNT_ZERO)) begin
              reg_num1 <= reg_num1 >> 4;
              r_cnt1   <= r_cnt1 - CNT_ONE;
            end
          end
          NUM2: begin
            if (w_is_digit) begin
              if (r_cnt2 == CNT_FULL) begin
                err <= 1'b1;
              end else begin
                reg_num2 <= {reg_num2[W-5:0], w_digit_val};
                r_cnt2   <= r_cnt2 + CNT_ONE;
              end
            end else if (w_is_op) begin
              // Operator may still be changed until the second operand starts
              if (r_cnt2 == CNT_ZERO) begin
                sym <= key_code;
              end else begin
                err <= 1'b1;
              end
            end else if (w_is_eq) begin
              if (r_cnt2 != CNT_ZERO) begin
                op_valid <= 1'b1;
                r_state  <= DONE;
                busy     <= 1'b0;
              end else begin
                err <= 1'b1;
              end
            end else if (w_is_bs) begin
              if (r_cnt2 != CNT_ZERO) begin
                reg_num2 <= reg_num2 >> 4;
                r_cnt2   <= r_cnt2 - CNT_ONE;
              end else begin
                sym     <= 8'h00;
                r_state <= NUM1;
                busy    <= 1'b0;
              end
            end
          end
          DONE: begin
            if (w_is_digit) begin
              reg_num1 <= {{(W-4){1'b0}}, w_digit_val};
              reg_num2 <= '0;
              sym      <= 8'h00;
              r_cnt1   <= CNT_ONE;
              r_cnt2   <= CNT_ZERO;
              r_state  <= NUM1;
            end else if (w_is_op || w_is_eq) begin
              err <= 1'b1;
            end
          end
          default: begin
            r_state <= NUM1;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_calc_key_entry.sv
// Self-checking bench for calc_key_entry: a table of per-cycle key vectors with
// hand-computed expected outputs, plus a hand-written op_valid pulse-width check.
module tb_calc_key_entry;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_valid;
  logic [7:0]  key_code;
  logic [11:0] reg_num1;
  logic [11:0] reg_num2;
  logic [7:0]  sym;
  logic        op_valid;
  logic        err;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  calc_key_entry #(.DIGITS(3), .KEY_CLR(8'h1B), .KEY_BS(8'h08)) dut (
    .clk       (clk),
    .rst       (rst),
    .key_valid (key_valid),
    .key_code  (key_code),
    .reg_num1  (reg_num1),
    .reg_num2  (reg_num2),
    .sym       (sym),
    .op_valid  (op_valid),
    .err       (err),
    .busy      (busy)
  );

  typedef struct {
    logic        r;
    logic        kv;
    logic [7:0]  k;
    logic [11:0] n1;
    logic [11:0] n2;
    logic [7:0]  s;
    logic        ov;
    logic        er;
    logic        bz;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic kv, input logic [7:0] k,
                     input logic [11:0] n1, input logic [11:0] n2, input logic [7:0] s,
                     input logic ov, input logic er, input logic bz);
    vec_t v;
    v.r = r; v.kv = kv; v.k = k; v.n1 = n1; v.n2 = n2; v.s = s;
    v.ov = ov; v.er = er; v.bz = bz;
    vecs.push_back(v);
  endtask

  // key with no reset
  task automatic key(input logic [7:0] k, input logic [11:0] n1, input logic [11:0] n2,
                     input logic [7:0] s, input logic ov, input logic er, input logic bz);
    add(1'b0, 1'b1, k, n1, n2, s, ov, er, bz);
  endtask

  task automatic check(input string name, input logic [34:0] act, input logic [34:0] exp_v);
    n_checks++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got n1=%h n2=%h sym=%h ov=%b err=%b busy=%b, want n1=%h n2=%h sym=%h ov=%b err=%b busy=%b",
                  name, act[34:23], act[22:11], act[10:3], act[2], act[1], act[0],
                  exp_v[34:23], exp_v[22:11], exp_v[10:3], exp_v[2], exp_v[1], exp_v[0]);
  endtask

  initial begin
    int ov_count;
    rst = 1'b1; key_valid = 1'b0; key_code = 8'h00;

    // reset
    add(1'b1, 1'b0, 8'h00, 12'h000, 12'h000, 8'h00, 1'b0, 1'b0, 1'b0);
    // 123 a 4 (b rejected) 5 e, then DONE rejections
    key(8'h31, 12'h001, 12'h000, 8'h00, 1'b0, 1'b0, 1'b0);
    key(8'h32, 12'h012, 12'h000, 8'h00, 1'b0, 1'b0, 1'b0);
    key(8'h33, 12'h123, 12'h000, 8'h00, 1'b0, 1'b0, 1'b0);
    key(8'h61, 12'h123, 12'h000, 8'h61, 1'b0, 1'b0, 1'b1);
    key(8'h34, 12'h123, 12'h004, 8'h61, 1'b0, 1'b0, 1'b1);
    key(8'h62, 12'h123, 12'h004, 8'h61, 1'b0, 1'b1, 1'b1);
    key(8'h7A, 12'h123, 12'h004, 8'h61, 1'b0, 1'b0, 1'b1);
    key(8'h35, 12'h123, 12'h045, 8'h61, 1'b0, 1'b0, 1'b1);
    key(8'h65, 12'h123, 12'h045, 8'h61, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 8'h65, 12'h123, 12'h045, 8'h61, 1'b0, 1'b0, 1'b0);
    key(8'h62, 12'h123, 12'h045, 8'h61, 1'b0, 1'b1, 1'b0);
    key(8'h65, 12'h123, 12'h045, 8'h61, 1'b0, 1'b1, 1'b0);
    key(8'h08, 12'h123, 12'h045, 8'h61, 1'b0, 1'b0, 1'b0);
    // 9999 from DONE: new calculation, err on 4th digit only
    key(8'h39, 12'h009, 12'h000, 8'h00, 1'b0, 1'b0, 1'b0);
    key(8'h39, 12'h099, 12'h000, 8'h00, 1'b0, 1'b0, 1'b0);
    key(8'h39, 12'h999, 12'h000, 8'h00, 1'b0, 1'b0, 1'b0);
    key(8'h39, 12'h999, 12'h000, 8'h00, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b0, 8'h00, 12'h999, 12'h000, 8'h00, 1'b0, 1'b0, 1'b0);
    key(8'h1B, 12'h000, 12'h000, 8'h00, 1'b0, 1'b0, 1'b0);
    // op and eq from empty NUM1
    key(8'h61, 12'h000, 12'h000, 8'h00, 1'b0, 1'b1, 1'b0);
    key(8'h65, 12'h000, 12'h000, 8'h00, 1'b0, 1'b1, 1'b0);
    // 7 c b 2 e, then 5 starts fresh
    key(8'h37, 12'h007, 12'h000, 8'h00, 1'b0, 1'b0, 1'b0);
    key(8'h63, 12'h007, 12'h000, 8'h63, 1'b0, 1'b0, 1'b1);
    key(8'h62, 12'h007, 12'h000, 8'h62, 1'b0, 1'b0, 1'b1);
    key(8'h32, 12'h007, 12'h002, 8'h62, 1'b0, 1'b0, 1'b1);
    key(8'h65, 12'h007, 12'h002, 8'h62, 1'b1, 1'b0, 1'b0);
    key(8'h35, 12'h005, 12'h000, 8'h00, 1'b0, 1'b0, 1'b0);
    // ESC, 1 2 BS a BS BS (BS) then a rejected since cnt1 is 0
    key(8'h1B, 12'h000, 12'h000, 8'h00, 1'b0, 1'b0, 1'b0);
    key(8'h31, 12'h001, 12'h000, 8'h00, 1'b0, 1'b0, 1'b0);
    key(8'h32, 12'h012, 12'h000, 8'h00, 1'b0, 1'b0, 1'b0);
    key(8'h08, 12'h001, 12'h000, 8'h00, 1'b0, 1'b0, 1'b0);
    key(8'h61, 12'h001, 12'h000, 8'h61, 1'b0, 1'b0, 1'b1);
    key(8'h08, 12'h001, 12'h000, 8'h00, 1'b0, 1'b0, 1'b0);
    key(8'h08, 12'h000, 12'h000, 8'h00, 1'b0, 1'b0, 1'b0);
    key(8'h08, 12'h000, 12'h000, 8'h00, 1'b0, 1'b0, 1'b0);
    key(8'h61, 12'h000, 12'h000, 8'h00, 1'b0, 1'b1, 1'b0);
    // 3 a 4, then reset coincident with 'e'
    key(8'h33, 12'h003, 12'h000, 8'h00, 1'b0, 1'b0, 1'b0);
    key(8'h61, 12'h003, 12'h000, 8'h61, 1'b0, 1'b0, 1'b1);
    key(8'h34, 12'h003, 12'h004, 8'h61, 1'b0, 1'b0, 1'b1);
    add(1'b1, 1'b1, 8'h65, 12'h000, 12'h000, 8'h00, 1'b0, 1'b0, 1'b0);
    key(8'h65, 12'h000, 12'h000, 8'h00, 1'b0, 1'b1, 1'b0);
    // 1 a 2, ESC mid-entry, then 'a' rejected in NUM1
    key(8'h31, 12'h001, 12'h000, 8'h00, 1'b0, 1'b0, 1'b0);
    key(8'h61, 12'h001, 12'h000, 8'h61, 1'b0, 1'b0, 1'b1);
    key(8'h32, 12'h001, 12'h002, 8'h61, 1'b0, 1'b0, 1'b1);
    key(8'h1B, 12'h000, 12'h000, 8'h00, 1'b0, 1'b0, 1'b0);
    key(8'h61, 12'h000, 12'h000, 8'h00, 1'b0, 1'b1, 1'b0);
    // 0 0 7 d 2 3 4 5: leading zeros, second operand overflow
    key(8'h30, 12'h000, 12'h000, 8'h00, 1'b0, 1'b0, 1'b0);
    key(8'h30, 12'h000, 12'h000, 8'h00, 1'b0, 1'b0, 1'b0);
    key(8'h37, 12'h007, 12'h000, 8'h00, 1'b0, 1'b0, 1'b0);
    key(8'h37, 12'h007, 12'h000, 8'h00, 1'b0, 1'b1, 1'b0);
    key(8'h64, 12'h007, 12'h000, 8'h64, 1'b0, 1'b0, 1'b1);
    key(8'h32, 12'h007, 12'h002, 8'h64, 1'b0, 1'b0, 1'b1);
    key(8'h33, 12'h007, 12'h023, 8'h64, 1'b0, 1'b0, 1'b1);
    key(8'h34, 12'h007, 12'h234, 8'h64, 1'b0, 1'b0, 1'b1);
    key(8'h35, 12'h007, 12'h234, 8'h64, 1'b0, 1'b1, 1'b1);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].r; key_valid = vecs[i].kv; key_code = vecs[i].k;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), {reg_num1, reg_num2, sym, op_valid, err, busy},
            {vecs[i].n1, vecs[i].n2, vecs[i].s, vecs[i].ov, vecs[i].er, vecs[i].bz});
    end

    // Hand sequence: 'e' completes the pending sum; op_valid must be exactly one cycle
    @(negedge clk);
    key_valid = 1'b1; key_code = 8'h65;
    @(negedge clk);
    key_valid = 1'b0; key_code = 8'h00;
    ov_count = (op_valid === 1'b1) ? 1 : 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (op_valid === 1'b1) ov_count++;
    end
    n_checks++;
    if (ov_count == 1) n_pass++;
    else $display("FAIL ov_pulse_width: got %0d cycles, want 1", ov_count);
    check("done_hold", {reg_num1, reg_num2, sym, op_valid, err, busy},
          {12'h007, 12'h234, 8'h64, 1'b0, 1'b0, 1'b0});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/calc_key_entry.md
Name: calc_key_entry

Overview:
- Front end of the calculator datapath.
- Accepts one ASCII keycode per strobe from the keyboard decoder and assembles two packed-BCD operands plus an operator code.
- Operator codes: 'a'/'b'/'c'/'d' = add/sub/mul/div. 'e' = equals.
- On a complete "operand op operand e" sequence it presents reg_num1, reg_num2 and sym stable, with a one-cycle op_valid pulse, to the arithmetic block.

Parameters:
- DIGITS, 3, max decimal digits per operand; operand width is 4*DIGITS.
- KEY_CLR, 8'h1B, clear-all keycode (ESC).
- KEY_BS, 8'h08, backspace keycode.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- key_valid  in  1  one-cycle strobe, key_code valid
- key_code  in  8  ASCII keycode
- reg_num1  out  4*DIGITS  first operand, packed BCD, most significant digit in the top nibble
- reg_num2  out  4*DIGITS  second operand, packed BCD
- sym  out  8  operator keycode (8'h61..8'h64), 8'h00 when none
- op_valid  out  1  one-cycle pulse: operands/sym complete and stable
- err  out  1  one-cycle pulse: rejected key
- busy  out  1  high in NUM2 state (operator accepted, awaiting '=')

Behaviour:
- Reset (rst high at an edge):
  - state=NUM1, cnt1=cnt2=0.
  - reg_num1, reg_num2, sym, op_valid, err all 0; busy=0.
  - rst has priority over key_valid.
- All outputs are registered; the effect of a key sampled at edge N is visible after edge N. op_valid and err are high for exactly the one cycle following edge N.
- Key classes:
  - digit: 8'h30..8'h39, value = code-8'h30.
  - op: 8'h61..8'h64.
  - eq: 8'h65.
  - KEY_CLR, KEY_BS.
  - Any other code is ignored silently (no err, no state change).
- Digit entry: operand <= {operand[4*DIGITS-5:0], value}; count++.
  - Digit when count==DIGITS: operand unchanged, err pulse.
- KEY_CLR, any state: identical to reset except no err.
- State NUM1:
  - digit: enters reg_num1.
  - op with cnt1>0: sym<=code, go NUM2.
  - op with cnt1==0: err.
  - eq: err.
  - KEY_BS with cnt1>0: reg_num1 <= reg_num1>>4, cnt1--.
  - KEY_BS with cnt1==0: no effect, no err.
- State NUM2:
  - digit: enters reg_num2.
  - op with cnt2==0: sym replaced by the new code.
  - op with cnt2>0: err.
  - eq with cnt2>0: op_valid pulse, go DONE.
  - eq with cnt2==0: err.
  - KEY_BS with cnt2>0: reg_num2 >>= 4, cnt2--.
  - KEY_BS with cnt2==0: sym<=0, go NUM1; reg_num1/cnt1 unchanged.
- State DONE:
  - Outputs held unchanged.
  - digit: clears reg_num2, sym, cnt2; reg_num1 <= value; cnt1<=1; go NUM1 (new calculation).
  - op, eq: err, hold.
  - KEY_BS: no effect.
- key_valid low: no state or output change; op_valid/err deassert.
- Back-to-back keys on consecutive cycles must each be processed.
- Leading zeros count as digits ("007" fills 3 digits).

Decomposition:
- Shared package calc_pkg holds:
  - state enum {NUM1, NUM2, DONE};
  - keycode constants KEY_ADD=8'h61, KEY_SUB=8'h62, KEY_MUL=8'h63, KEY_DIV=8'h64, KEY_EQ=8'h65, KEY_D0=8'h30, KEY_D9=8'h39. The arithmetic block imports the same constants.
- One sub-module, calc_key_class: combinational decode of key_code into {is_digit, is_op, is_eq, is_clr, is_bs, digit_val[3:0]}.
- The FSM and operand registers stay in calc_key_entry.

Test Plan:
- Keys '1','2','3','a','4','5','e' -> reg_num1=12'h123, reg_num2=12'h045, sym=8'h61, op_valid one cycle after 'e', busy low after 'e'.
- Keys '9','9','9','9' -> reg_num1=12'h999, err pulse on the 4th digit only.
- 'a' first, then 'e' from reset -> err pulse each time, state stays NUM1, sym=0.
- '7','c','b','2','e' -> sym=8'h62 (replaced), reg_num2=12'h002, op_valid. Then '5' -> reg_num1=12'h005, reg_num2=0, sym=0.
- '1','2',BS,'a',BS,BS -> reg_num1=12'h000, cnt1=0, state NUM1, sym=0, no err.
- '3','a','4' then rst high for one cycle coincident with key_valid 'e' -> all outputs 0, no op_valid. Then ESC mid-entry clears identically.
